// File: rtl/btn_event.sv
`default_nettype none
// ============================================================================
//  Module   : btn_event
//  Purpose  : Synchronise and debounce board buttons, then turn each press
//             into a single read-to-clear move event for the CPU.
//  Revision : 1.0  initial release
// ============================================================================
module btn_event #(
    parameter int N_BTN      = 5,
    parameter int DEB_CYCLES = 16,
    parameter int DW         = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn,
    input  logic             rd,
    output logic [DW-1:0]    rd_data,
    output logic             evt_valid,
    output logic             overrun
);

    localparam int                c_CNT_W   = $clog2(DEB_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEB_CYCLES - 1);

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] w_press;
    logic [2:0]       w_win_code;
    logic             w_any_press;
    logic             w_multi_press;
    logic [2:0]       r_code;
    logic             r_valid;
    logic             r_overrun;

    // Plain two-flop synchroniser; the first stage feeds nothing but the second.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_deb
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_stable;
        logic               w_accept;

        assign w_accept    = (r_sync2[gi] != r_stable) && (r_cnt == c_CNT_MAX);
        // A press is the very cycle the debounced level is about to go high.
        assign w_press[gi] = w_accept && r_sync2[gi];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt    <= '0;
                r_stable <= 1'b0;
            end else if (r_sync2[gi] == r_stable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync2[gi];
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    // Lowest index wins; scanning downward lets the lowest hit overwrite.
    always_comb begin
        w_win_code = 3'd0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (w_press[i]) begin
                w_win_code = 3'(i + 1);
            end
        end
    end

    assign w_any_press   = |w_press;
    // Clearing the lowest set bit leaves something only if two or more pressed.
    assign w_multi_press = |(w_press & (w_press - N_BTN'(1)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_code    <= 3'd0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_any_press) begin
            if (!r_valid || rd) begin
                r_code    <= w_win_code;
                r_valid   <= 1'b1;
                r_overrun <= rd ? w_multi_press : (r_overrun | w_multi_press);
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (rd) begin
            r_code    <= 3'd0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    always_comb begin
        rd_data      = '0;
        rd_data[2:0] = r_code;
        rd_data[16]  = r_valid;
        rd_data[17]  = r_overrun;
    end

    assign evt_valid = r_valid;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_btn_event.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_event
//  Purpose  : Self-checking bench for btn_event with an expected-event queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_btn_event;

    logic        clk;
    logic        rst_n;
    logic [4:0]  btn;
    logic        rd;
    logic [17:0] rd_data;
    logic        evt_valid;
    logic        overrun;

    int          total;
    int          bad;
    logic [17:0] exp_q[$];
    logic [17:0] exp_v;

    btn_event #(
        .N_BTN      (5),
        .DEB_CYCLES (16),
        .DW         (18)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .rd        (rd),
        .rd_data   (rd_data),
        .evt_valid (evt_valid),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_evt(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            tick(1);
            if (evt_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic consume();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn   = '0;
        rd    = 1'b0;
        tick(3);
        total++;
        if (rd_data !== 18'h0) begin
            bad++;
            $display("FAIL reset_rd_data: got %h want %h", rd_data, 18'h0);
        end
        total++;
        if (evt_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_evt_valid: got %b want 0", evt_valid);
        end
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_overrun: got %b want 0", overrun);
        end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_latency();
        bit seen;
        exp_q.push_back(18'h10003);
        btn[2] = 1'b1;
        tick(17);
        total++;
        if (evt_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_edge17: evt_valid got %b want 0", evt_valid);
        end
        tick(1);
        total++;
        if (evt_valid !== 1'b1) begin
            bad++;
            $display("FAIL latency_edge18: evt_valid got %b want 1", evt_valid);
        end
        exp_v = exp_q.pop_front();
        total++;
        if (rd_data !== exp_v) begin
            bad++;
            $display("FAIL latency_word: got %h want %h", rd_data, exp_v);
        end
        consume();
        total++;
        if (rd_data !== 18'h0) begin
            bad++;
            $display("FAIL consume: got %h want %h", rd_data, 18'h0);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (evt_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL no_autorepeat: event seen=%b want 0", seen);
        end
        btn = '0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (evt_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL release_no_event: event seen=%b want 0", seen);
        end
    endtask

    task automatic test_short_pulse();
        bit seen;
        bit ok;
        btn[0] = 1'b1;
        tick(15);
        btn[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (evt_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL short_pulse_15: event seen=%b want 0", seen);
        end
        // Sixteen cycles is the shortest pulse that must register.
        exp_q.push_back(18'h10001);
        btn[0] = 1'b1;
        tick(16);
        btn[0] = 1'b0;
        wait_evt(10, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL pulse_16_timeout: evt_valid got %b want 1", evt_valid);
        end
        exp_v = exp_q.pop_front();
        total++;
        if (rd_data !== exp_v) begin
            bad++;
            $display("FAIL pulse_16_word: got %h want %h", rd_data, exp_v);
        end
        consume();
        tick(40);
    endtask

    task automatic test_priority();
        bit ok;
        exp_q.push_back(18'h30002);
        btn = 5'b01010;
        wait_evt(40, ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL priority_timeout: evt_valid got %b want 1", evt_valid);
        end
        exp_v = exp_q.pop_front();
        total++;
        if (rd_data !== exp_v) begin
            bad++;
            $display("FAIL priority_word: got %h want %h", rd_data, exp_v);
        end
        consume();
        total++;
        if (rd_data !== 18'h0) begin
            bad++;
            $display("FAIL priority_cleared: got %h want %h", rd_data, 18'h0);
        end
        btn = '0;
        tick(40);
    endtask

    task automatic test_overrun();
        bit ok;
        exp_q.push_back(18'h10003);
        btn[2] = 1'b1;
        wait_evt(40, ok);
        exp_v = exp_q.pop_front();
        total++;
        if (!ok || rd_data !== exp_v) begin
            bad++;
            $display("FAIL overrun_first: got %h want %h", rd_data, exp_v);
        end
        exp_q.push_back(18'h30003);
        btn[4] = 1'b1;
        tick(25);
        exp_v = exp_q.pop_front();
        total++;
        if (rd_data !== exp_v) begin
            bad++;
            $display("FAIL overrun_code_kept: got %h want %h", rd_data, exp_v);
        end
        consume();
        total++;
        if (rd_data !== 18'h0) begin
            bad++;
            $display("FAIL overrun_rd_clears: got %h want %h", rd_data, 18'h0);
        end
        btn = '0;
        tick(40);
    endtask

    task automatic test_back_to_back();
        bit ok;
        exp_q.push_back(18'h30004);
        btn = 5'b11000;
        wait_evt(40, ok);
        exp_v = exp_q.pop_front();
        total++;
        if (!ok || rd_data !== exp_v) begin
            bad++;
            $display("FAIL b2b_pending: got %h want %h", rd_data, exp_v);
        end
        tick(2);
        exp_q.push_back(18'h10001);
        btn[0] = 1'b1;
        tick(17);
        rd = 1'b1;
        total++;
        if (rd_data !== 18'h30004) begin
            bad++;
            $display("FAIL b2b_rd_view: got %h want %h", rd_data, 18'h30004);
        end
        tick(1);
        rd = 1'b0;
        exp_v = exp_q.pop_front();
        total++;
        if (rd_data !== exp_v) begin
            bad++;
            $display("FAIL b2b_replace: got %h want %h", rd_data, exp_v);
        end
        consume();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
        total++;
        if (rd_data !== 18'h0) begin
            bad++;
            $display("FAIL rd_when_empty: got %h want %h", rd_data, 18'h0);
        end
        btn = '0;
        tick(40);
    endtask

    task automatic test_reset_mid();
        btn[2] = 1'b1;
        tick(12);
        rst_n = 1'b0;
        tick(1);
        total++;
        if (rd_data !== 18'h0 || evt_valid !== 1'b0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %h/%b/%b want 0/0/0",
                     rd_data, evt_valid, overrun);
        end
        rst_n = 1'b1;
        exp_q.push_back(18'h10003);
        tick(17);
        total++;
        if (evt_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_edge17: evt_valid got %b want 0", evt_valid);
        end
        tick(1);
        exp_v = exp_q.pop_front();
        total++;
        if (rd_data !== exp_v) begin
            bad++;
            $display("FAIL mid_reset_edge18: got %h want %h", rd_data, exp_v);
        end
        btn = '0;
        consume();
        tick(40);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        btn   = '0;
        rd    = 1'b0;
        test_reset();
        test_latency();
        test_short_pulse();
        test_priority();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
